// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - Tomasulo CDB arbiter: fixed priority with age promotion.
// Optional CDB_PERF_CNT_EN adds perf_bcast / perf_confl saturating counters.
module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk1,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_req,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_data,
    output logic [NUM_FU-1:0]        fu_gnt,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data,
    output logic [2:0]               cdb_src
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [15:0]              perf_bcast,
    output logic [15:0]              perf_confl
`endif
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0]        wait_cnt [NUM_FU];
    logic [NUM_FU-1:0] elig;
    logic [NUM_FU-1:0] promo;
    logic [2:0]        gnt_idx;
    logic              gnt_any;

    // Tag 0 means "no producer", so such requests are invisible to the arbiter.
    always_comb begin
        elig  = '0;
        promo = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            elig[i]  = fu_req[i] && (fu_tag[i*TAG_W +: TAG_W] != '0);
            promo[i] = elig[i] && (wait_cnt[i] == MAX_W);
        end
    end

    // Descending scans let the lowest index win; the promoted scan overrides the plain one.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        fu_gnt  = '0;
        if (!reset && !flush) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    gnt_idx = 3'(i);
                    gnt_any = 1'b1;
                end
            end
            for (int i = NUM_FU - 1; i >= 0; i--) begin
                if (promo[i]) gnt_idx = 3'(i);
            end
            if (gnt_any) fu_gnt = NUM_FU'(1) << gnt_idx;
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (gnt_any && !flush) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= fu_tag[gnt_idx*TAG_W +: TAG_W];
            cdb_data  <= fu_data[gnt_idx*DATA_W +: DATA_W];
            cdb_src   <= gnt_idx;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

    // A flush freezes ageing without forgetting it.
    always_ff @(posedge clk1) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (reset || fu_gnt[i] || !elig[i])
                wait_cnt[i] <= '0;
            else if (!flush && wait_cnt[i] != MAX_W)
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
    end

`ifdef CDB_PERF_CNT_EN
    logic multi_req;
    assign multi_req = |(elig & (elig - NUM_FU'(1)));

    always_ff @(posedge clk1) begin
        if (reset) begin
            perf_bcast <= '0;
            perf_confl <= '0;
        end else begin
            if (cdb_valid && perf_bcast != 16'hFFFF) perf_bcast <= perf_bcast + 16'd1;
            if (multi_req && perf_confl != 16'hFFFF) perf_confl <= perf_confl + 16'd1;
        end
    end
`endif

endmodule
